// File: rtl/log_rr_arb_pkg.sv
// Shared constants for the log stream arbiter: default flit width and FSM state codes.
package log_rr_arb_pkg;

    localparam int LOG_WIDTH = 32;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/log_rr_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching ptr+1, ptr+2, ... modulo N.
module rr_pick #(
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    int j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && (j < N) && req[j]) begin
                found = 1'b1;
                idx   = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/log_rr_arb.sv
// Packet-atomic round-robin merge of N_IN log streams into one registered AXI-Stream tagged with TID.
module log_rr_arb
    import log_rr_arb_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int DATA_WIDTH = LOG_WIDTH,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN*DATA_WIDTH-1:0] in_TDATA,
    input  logic [N_IN-1:0]            in_TVALID,
    input  logic [N_IN-1:0]            in_TLAST,
    output logic [N_IN-1:0]            in_TREADY,
    output logic [DATA_WIDTH-1:0]      out_TDATA,
    output logic                       out_TVALID,
    output logic                       out_TLAST,
    output logic [SEL_WIDTH-1:0]       out_TID,
    input  logic                       out_TREADY,
    output logic [15:0]                pkt_cnt,
    output logic [0:0]                 dbg_state
);

    // Handshake: a flit moves on any side only in a cycle where TVALID and TREADY are both 1.
    logic [0:0]            state;
    logic [SEL_WIDTH-1:0]  ptr;
    logic [SEL_WIDTH-1:0]  gnt;
    logic [SEL_WIDTH-1:0]  pick_idx;
    logic                  pick_found;
    logic [SEL_WIDTH-1:0]  cand;
    logic                  slot_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    assign dbg_state = state;

    rr_pick #(
        .N     (N_IN),
        .SEL_W (SEL_WIDTH)
    ) u_pick (
        .req   (in_TVALID),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign slot_free = !out_TVALID || out_TREADY;
    assign cand      = (state == ST_LOCKED) ? gnt : pick_idx;

    // A locked input keeps its ready even while idle so nobody else can sneak in mid-packet.
    always_comb begin
        in_TREADY = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (cand == SEL_WIDTH'(i)) begin
                in_TREADY[i] = slot_free && ((state == ST_LOCKED) || (in_TVALID[i] && pick_found));
                sel_data     = in_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last     = in_TLAST[i];
            end
        end
    end

    assign accept = |(in_TVALID & in_TREADY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_TVALID <= 1'b0;
            out_TDATA  <= '0;
            out_TLAST  <= 1'b0;
            out_TID    <= '0;
        end else if (accept) begin
            out_TVALID <= 1'b1;
            out_TDATA  <= sel_data;
            out_TLAST  <= sel_last;
            out_TID    <= cand;
        end else if (out_TREADY) begin
            out_TVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            ptr   <= SEL_WIDTH'(N_IN - 1);
            gnt   <= '0;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                if (sel_last) begin
                    ptr <= cand;
                end else begin
                    gnt   <= cand;
                    state <= ST_LOCKED;
                end
            end else if (sel_last) begin
                ptr   <= gnt;
                state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt <= '0;
        end else if (out_TVALID && out_TREADY && out_TLAST) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule
